// File: rtl/fma_read_buffer.sv
// -----------------------------------------------------------------------------
// fma_read_buffer
//
// Queues whole cache lines arriving from the memory stage and hands each
// head line to FMA_COUNT lanes as {a, b, c} word triples. Every lane has its
// own valid/ready handshake. The head line is popped once all lanes have
// taken their triple. The memory stage cannot be stalled, so the buffer
// reports its occupancy. A line that arrives while the buffer is full, with
// no pop in the same cycle, is dropped and recorded in a sticky flag.
//
// Ports:
//   clk_in         single clock, all logic on posedge
//   rst_in         synchronous active-low reset
//   abc_in         incoming line; word k at [LINE_WIDTH-(k+1)*WORD_WIDTH +: WORD_WIDTH]
//   abc_valid_in   one line per high cycle
//   fma_ready_in   per-lane ready
//   fma_valid_out  per-lane valid
//   a_out/b_out/c_out  per-lane words, lane i at [i*WORD_WIDTH +: WORD_WIDTH]
//   count_out      lines currently held
//   full_out       count_out == DEPTH
//   empty_out      count_out == 0
//   overflow_out   sticky: a line was dropped
//
// Optional feature, enabled by defining FMA_READ_BUFFER_STATS_EN:
//   lines_issued_out  16-bit wrapping count of popped lines
//   lane_stall_out    per lane: valid && !ready in the previous cycle
// -----------------------------------------------------------------------------
module fma_read_buffer #(
  parameter int FMA_COUNT  = 2,
  parameter int WORD_WIDTH = 16,
  parameter int LINE_WIDTH = 96,
  parameter int DEPTH      = 4
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [LINE_WIDTH-1:0]           abc_in,
  input  logic                            abc_valid_in,
  input  logic [FMA_COUNT-1:0]            fma_ready_in,
  output logic [FMA_COUNT-1:0]            fma_valid_out,
  output logic [FMA_COUNT*WORD_WIDTH-1:0] a_out,
  output logic [FMA_COUNT*WORD_WIDTH-1:0] b_out,
  output logic [FMA_COUNT*WORD_WIDTH-1:0] c_out,
  output logic [$clog2(DEPTH):0]          count_out,
  output logic                            full_out,
  output logic                            empty_out,
  output logic                            overflow_out
`ifdef FMA_READ_BUFFER_STATS_EN
  ,
  output logic [15:0]                     lines_issued_out,
  output logic [FMA_COUNT-1:0]            lane_stall_out
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (LINE_WIDTH != FMA_COUNT * 3 * WORD_WIDTH) begin : g_bad_width
    $error("LINE_WIDTH must equal FMA_COUNT*3*WORD_WIDTH");
  end

  typedef enum logic {ST_EMPTY, ST_ISSUE} state_e;

  state_e                 state_q, state_d;
  logic [LINE_WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [FMA_COUNT-1:0]   taken_q, taken_d;
  logic                   overflow_q, overflow_d;

  logic [FMA_COUNT-1:0]   lane_valid;
  logic [FMA_COUNT-1:0]   fire;
  logic                   pop;
  logic                   accept;
  logic [LINE_WIDTH-1:0]  head;

  assign head = mem_q[rd_ptr_q];

  // Handshake, pointer, counter and taken-mask next state.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // through the block leaves it unassigned and no latch is inferred.
    lane_valid = '0;
    if (state_q == ST_ISSUE) lane_valid = ~taken_q;
    fire   = lane_valid & fma_ready_in;
    // The head retires on the edge where the last outstanding lane fires.
    pop    = (state_q == ST_ISSUE) && (&(taken_q | fire));
    // A full buffer can still take a line if a slot frees this same edge.
    accept = abc_valid_in && ((count_q < CNT_W'(DEPTH)) || pop);

    wr_ptr_d   = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    taken_d    = pop ? '0 : (taken_q | fire);
    overflow_d = overflow_q | (abc_valid_in && !accept);

    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Line-level FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_ISSUE;
      ST_ISSUE: if (pop && (count_q == CNT_W'(1)) && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Line-level FSM: state register plus control registers.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_in) begin
      state_q    <= ST_EMPTY;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      taken_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      taken_q    <= taken_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: line storage has no reset; contents are only observable while the
  // buffer is non-empty, and the outputs are forced to zero otherwise.
  always_ff @(posedge clk_in) begin
    if (rst_in && accept) mem_q[wr_ptr_q] <= abc_in;
  end

  // Line-level FSM: outputs.
  always_comb begin
    fma_valid_out = lane_valid;
    count_out     = count_q;
    full_out      = (count_q == CNT_W'(DEPTH));
    empty_out     = (state_q == ST_EMPTY);
    overflow_out  = overflow_q;
    a_out = '0;
    b_out = '0;
    c_out = '0;
    if (state_q == ST_ISSUE) begin
      for (int i = 0; i < FMA_COUNT; i++) begin
        a_out[i*WORD_WIDTH +: WORD_WIDTH] = head[LINE_WIDTH-(3*i+1)*WORD_WIDTH +: WORD_WIDTH];
        b_out[i*WORD_WIDTH +: WORD_WIDTH] = head[LINE_WIDTH-(3*i+2)*WORD_WIDTH +: WORD_WIDTH];
        c_out[i*WORD_WIDTH +: WORD_WIDTH] = head[LINE_WIDTH-(3*i+3)*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

`ifdef FMA_READ_BUFFER_STATS_EN
  logic [15:0]          lines_issued_q;
  logic [FMA_COUNT-1:0] lane_stall_q;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      lines_issued_q <= '0;
      lane_stall_q   <= '0;
    end else begin
      if (pop) lines_issued_q <= lines_issued_q + 16'd1;
      lane_stall_q <= lane_valid & ~fma_ready_in;
    end
  end

  assign lines_issued_out = lines_issued_q;
  assign lane_stall_out   = lane_stall_q;
`endif

endmodule

// File: tb/tb_fma_read_buffer.sv
// -----------------------------------------------------------------------------
// tb_fma_read_buffer
//
// Testbench for fma_read_buffer with its default parameters. A vector table
// covers the single-line, back-to-back and fill/overflow cases cycle by cycle.
// Hand-written sequences cover skewed lanes, push/pop while full and reset in
// the middle of a handshake. Inputs change on the falling edge; outputs are
// compared just before the inputs change.
// -----------------------------------------------------------------------------
module tb_fma_read_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [95:0] abc_in;
  logic        abc_valid_in;
  logic [1:0]  fma_ready_in;
  logic [1:0]  fma_valid_out;
  logic [31:0] a_out, b_out, c_out;
  logic [2:0]  count_out;
  logic        full_out, empty_out, overflow_out;

  int checks = 0;
  int errors = 0;

  fma_read_buffer dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .abc_in        (abc_in),
    .abc_valid_in  (abc_valid_in),
    .fma_ready_in  (fma_ready_in),
    .fma_valid_out (fma_valid_out),
    .a_out         (a_out),
    .b_out         (b_out),
    .c_out         (c_out),
    .count_out     (count_out),
    .full_out      (full_out),
    .empty_out     (empty_out),
    .overflow_out  (overflow_out)
  );

  always #5 clk_in = ~clk_in;

  // Line id n: word k = n*256 + k + 1, so id 0 is 0001_0002_..._0006.
  function automatic logic [15:0] word_of(int n, int k);
    return 16'(n * 256 + k + 1);
  endfunction

  function automatic logic [95:0] line_of(int n);
    logic [95:0] l = '0;
    for (int k = 0; k < 6; k++) l[95-16*k -: 16] = word_of(n, k);
    return l;
  endfunction

  // sel 0/1/2 = a/b/c; lane 1 in the upper half. id < 0 means all zero.
  function automatic logic [31:0] lane_words(int n, int sel);
    if (n < 0) return 32'h0;
    return {word_of(n, 3 + sel), word_of(n, sel)};
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [1:0] ev, input int eid,
                         input int cnt, input logic full, input logic empty,
                         input logic ovf);
    check({nm, ".valid"}, 96'(fma_valid_out), 96'(ev));
    check({nm, ".a"}, 96'(a_out), 96'(lane_words(eid, 0)));
    check({nm, ".b"}, 96'(b_out), 96'(lane_words(eid, 1)));
    check({nm, ".c"}, 96'(c_out), 96'(lane_words(eid, 2)));
    check({nm, ".count"}, 96'(count_out), 96'(cnt));
    check({nm, ".full"}, 96'(full_out), 96'(full));
    check({nm, ".empty"}, 96'(empty_out), 96'(empty));
    check({nm, ".ovf"}, 96'(overflow_out), 96'(ovf));
  endtask

  // Called on a falling edge; the next rising edge samples these inputs.
  task automatic drv(input logic push, input int id, input logic [1:0] rdy);
    abc_valid_in = push;
    abc_in       = push ? line_of(id) : 96'h0;
    fma_ready_in = rdy;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
    drv(1'b0, 0, 2'b00);
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  typedef struct {
    logic       push;
    int         id;
    logic [1:0] rdy;
    logic [1:0] ev;
    int         eid;
    int         cnt;
    logic       full;
    logic       empty;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic push, input int id, input logic [1:0] rdy,
                     input logic [1:0] ev, input int eid, input int cnt,
                     input logic full, input logic empty, input logic ovf);
    vec_t v;
    v.push = push; v.id = id; v.rdy = rdy; v.ev = ev; v.eid = eid;
    v.cnt = cnt; v.full = full; v.empty = empty; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  initial begin
    rst_in = 1'b0;
    drv(1'b0, 0, 2'b00);

    // Each row: inputs for this cycle's edge, outputs expected before it.
    // Single line with both lanes ready.
    add(0, 0, 2'b11, 2'b00, -1, 0, 0, 1, 0);
    add(1, 0, 2'b11, 2'b00, -1, 0, 0, 1, 0);
    add(0, 0, 2'b11, 2'b11,  0, 1, 0, 0, 0);
    add(0, 0, 2'b11, 2'b00, -1, 0, 0, 1, 0);
    // Back-to-back lines 1..3.
    add(1, 1, 2'b11, 2'b00, -1, 0, 0, 1, 0);
    add(1, 2, 2'b11, 2'b11,  1, 1, 0, 0, 0);
    add(1, 3, 2'b11, 2'b11,  2, 1, 0, 0, 0);
    add(0, 0, 2'b11, 2'b11,  3, 1, 0, 0, 0);
    add(0, 0, 2'b11, 2'b00, -1, 0, 0, 1, 0);
    // Fill with lines 4..7, line 8 dropped, then drain.
    add(1, 4, 2'b00, 2'b00, -1, 0, 0, 1, 0);
    add(1, 5, 2'b00, 2'b11,  4, 1, 0, 0, 0);
    add(1, 6, 2'b00, 2'b11,  4, 2, 0, 0, 0);
    add(1, 7, 2'b00, 2'b11,  4, 3, 0, 0, 0);
    add(1, 8, 2'b00, 2'b11,  4, 4, 1, 0, 0);
    add(0, 0, 2'b00, 2'b11,  4, 4, 1, 0, 1);
    add(0, 0, 2'b11, 2'b11,  4, 4, 1, 0, 1);
    add(0, 0, 2'b11, 2'b11,  5, 3, 0, 0, 1);
    add(0, 0, 2'b11, 2'b11,  6, 2, 0, 0, 1);
    add(0, 0, 2'b11, 2'b11,  7, 1, 0, 0, 1);
    add(0, 0, 2'b11, 2'b00, -1, 0, 0, 1, 1);
    add(0, 0, 2'b00, 2'b00, -1, 0, 0, 1, 1);

    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_in);
      chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eid, vecs[i].cnt,
              vecs[i].full, vecs[i].empty, vecs[i].ovf);
      drv(vecs[i].push, vecs[i].id, vecs[i].rdy);
    end

    // Skewed lanes: lane 0 takes at once, lane 1 only after three cycles.
    do_reset();
    chk_out("skew0", 2'b00, -1, 0, 0, 1, 0);
    drv(1, 9, 2'b00);
    @(negedge clk_in); chk_out("skew1", 2'b11, 9, 1, 0, 0, 0); drv(0, 0, 2'b01);
    @(negedge clk_in); chk_out("skew2", 2'b10, 9, 1, 0, 0, 0); drv(0, 0, 2'b01);
    @(negedge clk_in); chk_out("skew3", 2'b10, 9, 1, 0, 0, 0); drv(0, 0, 2'b01);
    @(negedge clk_in); chk_out("skew4", 2'b10, 9, 1, 0, 0, 0); drv(0, 0, 2'b10);
    @(negedge clk_in); chk_out("skew5", 2'b00, -1, 0, 0, 1, 0); drv(0, 0, 2'b00);

    // Full buffer: head completes on the same edge a new line arrives.
    do_reset();
    drv(1, 10, 2'b00);
    @(negedge clk_in); chk_out("fpp1", 2'b11, 10, 1, 0, 0, 0); drv(1, 11, 2'b00);
    @(negedge clk_in); chk_out("fpp2", 2'b11, 10, 2, 0, 0, 0); drv(1, 12, 2'b00);
    @(negedge clk_in); chk_out("fpp3", 2'b11, 10, 3, 0, 0, 0); drv(1, 13, 2'b00);
    @(negedge clk_in); chk_out("fpp4", 2'b11, 10, 4, 1, 0, 0); drv(1, 14, 2'b11);
    @(negedge clk_in); chk_out("fpp5", 2'b11, 11, 4, 1, 0, 0); drv(0, 0, 2'b11);
    @(negedge clk_in); chk_out("fpp6", 2'b11, 12, 3, 0, 0, 0);
    @(negedge clk_in); chk_out("fpp7", 2'b11, 13, 2, 0, 0, 0);
    @(negedge clk_in); chk_out("fpp8", 2'b11, 14, 1, 0, 0, 0);
    @(negedge clk_in); chk_out("fpp9", 2'b00, -1, 0, 0, 1, 0); drv(0, 0, 2'b00);

    // Reset with two lines queued and lane 0 already taken.
    drv(1, 15, 2'b00);
    @(negedge clk_in); chk_out("rst1", 2'b11, 15, 1, 0, 0, 0); drv(1, 16, 2'b01);
    @(negedge clk_in); chk_out("rst2", 2'b10, 15, 2, 0, 0, 0);
    rst_in = 1'b0; drv(0, 0, 2'b00);
    @(negedge clk_in); chk_out("rst3", 2'b00, -1, 0, 0, 1, 0);
    rst_in = 1'b1; drv(1, 17, 2'b00);
    @(negedge clk_in); chk_out("rst4", 2'b11, 17, 1, 0, 0, 0); drv(0, 0, 2'b11);
    @(negedge clk_in); chk_out("rst5", 2'b00, -1, 0, 0, 1, 0); drv(0, 0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fma_read_buffer.md
Name: fma_read_buffer

Overview:
- Downstream consumer of the data-cache memory stage's `abc_out`/`abc_valid_out` line output.
- Queues whole lines in a small FIFO, splits the head line into per-FMA a/b/c word triples, and hands each triple to its FMA lane with an independent valid/ready handshake.
- Pops the head line only after every lane has accepted its triple.
- Memory has no ready input, so this block reports occupancy (`full_out`/`count_out`) to the controller, which throttles `writeb` issue.

Parameters:
- FMA_COUNT, 2, number of FMA lanes fed per line.
- WORD_WIDTH, 16, bits per word.
- LINE_WIDTH, 96, line width; must equal FMA_COUNT*3*WORD_WIDTH.
- DEPTH, 4, FIFO depth in lines; power of two, >= 2.

Ports:
- clk_in  input  1  single clock, all logic on posedge.
- rst_in  input  1  reset, synchronous, active-low.
- abc_in  input  LINE_WIDTH  line from memory stage; word k at [LINE_WIDTH-(k+1)*WORD_WIDTH +: WORD_WIDTH] (word 0 at MSBs).
- abc_valid_in  input  1  one-cycle pulse; one line per high cycle.
- fma_ready_in  input  FMA_COUNT  lane i ready to accept its triple.
- fma_valid_out  output  FMA_COUNT  lane i triple valid.
- a_out  output  FMA_COUNT*WORD_WIDTH  lane i at [i*WORD_WIDTH +: WORD_WIDTH].
- b_out  output  FMA_COUNT*WORD_WIDTH  same packing as a_out.
- c_out  output  FMA_COUNT*WORD_WIDTH  same packing as a_out.
- count_out  output  $clog2(DEPTH)+1  lines currently held.
- full_out  output  1  count_out == DEPTH.
- empty_out  output  1  count_out == 0.
- overflow_out  output  1  sticky; a line was dropped.

Behaviour:
- Reset (rst_in==0 at posedge):
  - wr/rd pointers, count, taken mask and overflow cleared.
  - Outputs: fma_valid_out=0, count_out=0, full_out=0, empty_out=1, overflow_out=0.
  - a/b/c_out=0.
  - Reset mid-handshake discards all queued lines; no lane sees valid in the cycle after reset.
- Lane mapping: lane i gets a = word 3i, b = word 3i+1, c = word 3i+2 of the head line.
- Storage: DEPTH x LINE_WIDTH register array, wr_ptr/rd_ptr wrap modulo DEPTH.
- a/b/c_out are driven from the head entry and are zero when empty.
- Latency: abc_valid_in high at edge N into an empty buffer gives fma_valid_out all ones during cycle N+1. No combinational path from abc_in to outputs.
- Per-lane state (taken mask, one bit per lane):
  - fma_valid_out[i] = !empty && !taken[i].
  - Lane i fires when fma_valid_out[i] && fma_ready_in[i]; taken[i] is set at that edge.
  - Once taken, lane i's valid stays low until the next head line is presented.
- Pop: at the edge where (taken | fire) is all ones, rd_ptr advances and taken is cleared. If another line is queued, all lanes present it in the next cycle (back-to-back, no bubble). Lanes may complete in any order and in any cycles.
- Line-level state machine:
  - EMPTY --push--> ISSUE.
  - ISSUE --pop && count==1 && !push--> EMPTY.
  - ISSUE --pop, other lines remain--> ISSUE (new head).
- Push rules:
  - Push is accepted when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
  - Otherwise the line is dropped, overflow_out is set (sticky until reset), and count is unchanged.
- Simultaneous push and pop: count unchanged and both pointers advance.
- Push into an empty buffer with ready asserted: the line is not consumable until N+1.
- count_out, full_out and empty_out are registered and reflect the post-edge state.
- fma_ready_in with valid low is ignored and has no side effect.

Optional Feature:
- Macro: FMA_READ_BUFFER_STATS_EN.
- Defined:
  - Adds output `lines_issued_out` [15:0]: increments on every pop, wraps 0xFFFF->0, reset to 0.
  - Adds output `lane_stall_out` [FMA_COUNT-1:0]: registered, bit i = fma_valid_out[i] && !fma_ready_in[i] in the previous cycle.
- Undefined: both ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Reset and single line:
  - Stimulus: reset, then one pulse with abc_in=96'h0001_0002_0003_0004_0005_0006, fma_ready_in=2'b11.
  - Next cycle requires fma_valid_out=2'b11, a_out={16'h0004,16'h0001}, b_out={16'h0005,16'h0002}, c_out={16'h0006,16'h0003}.
  - Following cycle requires empty_out=1 and count_out=0.
- Skewed lanes:
  - Stimulus: one line; ready=2'b01 for 3 cycles, then 2'b10.
  - Lane 0 valid drops after 1 cycle; lane 1 valid is held for 4 cycles; pop occurs on lane 1 fire; count 1->0.
- Back-to-back:
  - Stimulus: 3 lines pushed on consecutive cycles, ready=2'b11 throughout.
  - Lines emerge on 3 consecutive cycles, in order, with no bubble.
- Fill and overflow (DEPTH=4):
  - Stimulus: ready=0, push 5 lines.
  - Required: full_out=1 after the 4th push; the 5th line is dropped; overflow_out=1 and stays 1.
  - Then ready=2'b11 drains exactly the first 4 lines.
- Full with simultaneous push/pop:
  - Stimulus: buffer full with the head's lanes completing while a new push arrives.
  - Required: push accepted, overflow_out stays 0, count_out stays 4.
- Reset mid-operation:
  - Stimulus: 2 lines queued, lane 0 already taken, rst_in=0 for one cycle.
  - Required: next cycle fma_valid_out=0, count_out=0, empty_out=1; a subsequent push is presented to both lanes fresh.
